decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/rv_decode_pkg.sv | 46 ++++
 rtl/id_regfile.sv | 45 ++++
 rtl/decode_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV opcode constants, decoded control bundle and control decode helpers.
package rv_decode_pkg;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] alu_op_base;
        logic [6:0] alu_op_ext;
        logic       alu_src;
        logic       reg_write;
        logic       wb_from_load;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
    } dec_ctrl_t;

    function automatic logic is_shift_imm(input logic [6:0] op, input logic [2:0] funct3);
        return op == OP_IMM && (funct3 == 3'd1 || funct3 == 3'd5);
    endfunction

    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] op, input logic [2:0] funct3,
                                              input logic [6:0] funct7, input logic [4:0] rd);
        dec_ctrl_t c;
        logic      ldst;
        ldst           = op == LOAD || op == STORE;
        c.rd           = rd;
        c.alu_op_base  = ldst ? 3'd0 : funct3;
        c.alu_op_ext   = (op == OP || is_shift_imm(op, funct3)) ? funct7 : 7'd0;
        c.alu_src      = op == OP_IMM || ldst;
        c.reg_write    = !(op == BRANCH || op == STORE || op == SYSTEM);
        c.wb_from_load = op == LOAD;
        c.mem_read     = op == LOAD;
        c.mem_write    = op == STORE;
        c.is_branch    = op == BRANCH;
        return c;
    endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREGS x XLEN register file, 2 async reads, 1 sync write.
// DECODE_STAGE_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    localparam int IW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr, ok1, ok2;

    // x0 and out-of-range indices never store and always read as zero
    assign wr  = wb_en && wb_rd != 5'd0 && {1'b0, wb_rd} < 6'(NREGS);
    assign ok1 = rs1_addr != 5'd0 && {1'b0, rs1_addr} < 6'(NREGS);
    assign ok2 = rs2_addr != 5'd0 && {1'b0, rs2_addr} < 6'(NREGS);

`ifdef DECODE_STAGE_WB_BYPASS_EN
    assign rs1_data = !ok1 ? '0 : (wr && wb_rd == rs1_addr) ? wb_data : regs_q[rs1_addr[IW-1:0]];
    assign rs2_data = !ok2 ? '0 : (wr && wb_rd == rs2_addr) ? wb_data : regs_q[rs2_addr[IW-1:0]];
`else
    assign rs1_data = ok1 ? regs_q[rs1_addr[IW-1:0]] : '0;
    assign rs2_data = ok2 ? regs_q[rs2_addr[IW-1:0]] : '0;
`endif

    always_comb begin
        regs_d = regs_q;
        if (wr) regs_d[wb_rd[IW-1:0]] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV instruction decode with one output register, load-use stall and flush.
// DECODE_STAGE_WB_BYPASS_EN enables write-back bypass instead of a one-cycle write-back stall.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_alu_op_base,
    output logic [6:0]      out_alu_op_ext,
    output logic            out_alu_src,
    output logic            out_reg_write,
    output logic            out_wb_from_load,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_is_branch
);
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2;
    logic            use_rs1, use_rs2, load_haz, wb_haz, hazard, accept;
    logic [XLEN-1:0] rd1, rd2, imm, shamt;
    dec_ctrl_t       ctrl;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    dec_ctrl_t       ctrl_q, ctrl_d;

    assign op      = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign rs1     = in_instr[19:15];
    assign rs2     = in_instr[24:20];
    assign use_rs1 = !(op == LUI || op == AUIPC || op == JAL);
    assign use_rs2 = op == OP || op == STORE || op == BRANCH;
    assign ctrl    = decode_ctrl(op, funct3, in_instr[31:25], in_instr[11:7]);

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1), .rs2_addr(rs2), .rs1_data(rd1), .rs2_data(rd2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    assign load_haz = valid_q && ctrl_q.wb_from_load && ctrl_q.rd != 5'd0 &&
                      ((use_rs1 && rs1 == ctrl_q.rd) || (use_rs2 && rs2 == ctrl_q.rd));
`ifdef DECODE_STAGE_WB_BYPASS_EN
    assign wb_haz = 1'b0;
`else
    // without bypass the read would see the stale value, so wait for the write to land
    assign wb_haz = wb_en && wb_rd != 5'd0 &&
                    ((use_rs1 && rs1 == wb_rd) || (use_rs2 && rs2 == wb_rd));
`endif
    assign hazard   = load_haz || wb_haz;
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush && rst;
    assign accept   = in_valid && in_ready;

    assign shamt = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
    assign imm   = is_shift_imm(op, funct3) ? shamt :
                   (op == OP_IMM || op == LOAD || op == JALR || op == SYSTEM) ? XLEN'($signed(in_instr[31:20])) :
                   op == STORE  ? XLEN'($signed({in_instr[31:25], in_instr[11:7]})) :
                   op == BRANCH ? XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0})) :
                   (op == LUI || op == AUIPC) ? XLEN'($signed({in_instr[31:12], 12'b0})) :
                   op == JAL    ? XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0})) :
                   '0;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            rs1_d   = rd1;
            rs2_d   = rd2;
            imm_d   = imm;
            ctrl_d  = ctrl;
        end else if (flush || out_ready) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            imm_d   = '0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_pc           = pc_q;
    assign out_rs1_val      = rs1_q;
    assign out_rs2_val      = rs2_q;
    assign out_imm          = imm_q;
    assign out_rd           = ctrl_q.rd;
    assign out_alu_op_base  = ctrl_q.alu_op_base;
    assign out_alu_op_ext   = ctrl_q.alu_op_ext;
    assign out_alu_src      = ctrl_q.alu_src;
    assign out_reg_write    = ctrl_q.reg_write;
    assign out_wb_from_load = ctrl_q.wb_from_load;
    assign out_mem_read     = ctrl_q.mem_read;
    assign out_mem_write    = ctrl_q.mem_write;
    assign out_is_branch    = ctrl_q.is_branch;
endmodule
